// File: rtl/capture_serializer.sv
// capture_serializer
//   Captures a programmable-length record of SAMPLE_W-bit sample words into
//   block RAM, then drains it as an OUT_W-bit byte stream with a valid/ready
//   handshake.
//
// Ports
//   ReadClock, Reset      single clock; synchronous active-high reset
//   SampleIn/SampleValid  sample words from the upstream CDC FIFO
//   Arm                   capture request, only honoured in IDLE
//   TriggerMode           0: store right after Arm, 1: wait for Trigger
//   Trigger               trigger strobe (the coincident sample is word 0)
//   CaptureLength         record length in words; 0 or > DEPTH means DEPTH
//   DataOut/DataValid     byte stream, held stable while DataReady is low
//   DataReady             consumer accept
//   StoreActive           high while storing
//   DataReadyToSend       high while sending
//   Done                  one-cycle pulse after the last byte is accepted
//   State                 IDLE=00 ARMED=01 STORING=10 SENDING=11
module capture_serializer #(
    parameter int SAMPLE_W  = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 1024,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     ReadClock,
    input  logic                     Reset,
    input  logic [SAMPLE_W-1:0]      SampleIn,
    input  logic                     SampleValid,
    input  logic                     Arm,
    input  logic                     TriggerMode,
    input  logic                     Trigger,
    input  logic [$clog2(DEPTH):0]   CaptureLength,
    output logic [OUT_W-1:0]         DataOut,
    output logic                     DataValid,
    input  logic                     DataReady,
    output logic                     StoreActive,
    output logic                     DataReadyToSend,
    output logic                     Done,
    output logic [1:0]               State
);
    localparam int AW = $clog2(DEPTH);
    localparam int R  = SAMPLE_W / OUT_W;
    localparam int BW = (R > 1) ? $clog2(R) : 1;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(R-1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        STORING = 2'b10,
        SENDING = 2'b11
    } state_t;

    state_t state, stateNext;

    logic [SAMPLE_W-1:0] mem [DEPTH];

    logic [AW:0] len, wptr, rptr, lenArm, wrAddr, wrCount;
    logic        wrEn;

    // Read path: ramQ is the registered RAM output and doubles as the
    // one-word prefetch; curWord is the word being serialized.
    logic [SAMPLE_W-1:0]         ramQ;
    logic                        qValid;
    logic [R-1:0][OUT_W-1:0]     curWord;
    logic                        curValid;
    logic [BW-1:0]               byteIdx, selIdx;
    logic accept, lastByte, curFree, loadCur, rdEn, finalAccept;

    always_comb begin
        lenArm = CaptureLength;
        if (CaptureLength == '0 || CaptureLength > FULL) lenArm = FULL;
    end

    // A trigger cycle in ARMED stores the coincident sample as word 0.
    assign wrEn    = SampleValid && (state == STORING || (state == ARMED && Trigger));
    assign wrAddr  = (state == ARMED) ? '0 : wptr;
    assign wrCount = wrAddr + ONE;

    assign accept   = DataValid && DataReady;
    assign lastByte = (byteIdx == LAST_BYTE);
    assign curFree  = !curValid || (accept && lastByte);
    assign loadCur  = curFree && qValid;
    // Refill the prefetch whenever it is empty or being handed over, so a
    // new word is ready by the time the current one runs out.
    assign rdEn     = (state == SENDING) && (rptr < len) && (!qValid || loadCur);
    // Last byte of the record: nothing left to read and nothing prefetched.
    assign finalAccept = accept && lastByte && !qValid && (rptr == len);

    always_ff @(posedge ReadClock) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext       = state;
        StoreActive     = 1'b0;
        DataReadyToSend = 1'b0;
        case (state)
            IDLE: begin
                if (Arm) stateNext = TriggerMode ? ARMED : STORING;
            end
            ARMED: begin
                if (Trigger) stateNext = (wrEn && wrCount == len) ? SENDING : STORING;
            end
            STORING: begin
                StoreActive = 1'b1;
                if (wrEn && wrCount == len) stateNext = SENDING;
            end
            SENDING: begin
                DataReadyToSend = 1'b1;
                if (finalAccept) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            len      <= FULL;
            wptr     <= '0;
            rptr     <= '0;
            qValid   <= 1'b0;
            curWord  <= '0;
            curValid <= 1'b0;
            byteIdx  <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= finalAccept;
            if (state == IDLE && Arm) len <= lenArm;

            // wptr sits at zero until storing starts.
            if (state == IDLE) wptr <= '0;
            else if (wrEn)     wptr <= wrCount;

            if (state != SENDING) begin
                rptr     <= '0;
                qValid   <= 1'b0;
                curValid <= 1'b0;
                byteIdx  <= '0;
            end else begin
                if (rdEn)         rptr <= rptr + ONE;
                if (rdEn)         qValid <= 1'b1;
                else if (loadCur) qValid <= 1'b0;
                if (loadCur) begin
                    curWord  <= ramQ;
                    curValid <= 1'b1;
                    byteIdx  <= '0;
                end else if (accept) begin
                    byteIdx <= byteIdx + BW'(1);
                    if (lastByte) curValid <= 1'b0;
                end
            end
        end
    end

    // Block RAM: no reset on contents or read register.
    always_ff @(posedge ReadClock) begin
        if (wrEn) mem[wrAddr[AW-1:0]] <= SampleIn;
        if (rdEn) ramQ <= mem[rptr[AW-1:0]];
    end

    assign selIdx    = MSB_FIRST ? (LAST_BYTE - byteIdx) : byteIdx;
    assign DataOut   = curWord[selIdx];
    assign DataValid = curValid;
    assign State     = state;

endmodule
